// File: rtl/regfile_write_arbiter_if.sv
// Requester-side and register-file-side signals of the shared write port.
// The requesters (master) present valid/addr/data and the stall input; the
// arbiter (slave) returns the one-hot grant and drives the registered write port.
interface regfile_write_arbiter_if #(
  parameter int ADDR = 4,
  parameter int SIZE = 32,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      Req_Valid;
  logic [NREQ*ADDR-1:0] Req_Addr;
  logic [NREQ*SIZE-1:0] Req_Data;
  logic [NREQ-1:0]      Req_Ready;
  logic                 Hold;
  logic                 Write_Reg;
  logic [ADDR-1:0]      W_Addr;
  logic [SIZE-1:0]      W_Data;
  logic [2:0]           Grant_Idx;
  logic                 Collision;

  modport master (
    output Req_Valid, Req_Addr, Req_Data, Hold,
    input  Req_Ready, Write_Reg, W_Addr, W_Data, Grant_Idx, Collision
  );

  modport slave (
    input  Req_Valid, Req_Addr, Req_Data, Hold,
    output Req_Ready, Write_Reg, W_Addr, W_Data, Grant_Idx, Collision
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NREQ valid/ready requesters. Stage _p0 is the combinational grant decision,
// stage _p1 is the registered write port that feeds the register file.
module regfile_write_arbiter #(
  parameter int ADDR = 4,
  parameter int SIZE = 32,
  parameter int NREQ = 3
) (
  input  logic                   Clk,
  input  logic                   Clr,
  regfile_write_arbiter_if.slave bus
);

  // ---- stage p0: combinational arbitration ----
  logic [2:0]      ptr;
  logic            found_p0;
  logic [2:0]      winner_p0;
  logic            grant_en_p0;
  logic [NREQ-1:0] ready_p0;
  logic [ADDR-1:0] addr_sel_p0;
  logic [SIZE-1:0] data_sel_p0;
  logic            collision_p0;
  logic [2:0]      ptr_next_p0;

  // Pick the first valid requester scanning Ptr..NREQ-1, then 0..Ptr-1.
  always_comb begin
    found_p0  = 1'b0;
    winner_p0 = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_p0 && (i >= int'(ptr)) && bus.Req_Valid[i]) begin
        found_p0  = 1'b1;
        winner_p0 = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_p0 && (i < int'(ptr)) && bus.Req_Valid[i]) begin
        found_p0  = 1'b1;
        winner_p0 = 3'(i);
      end
    end
  end

  // A grant is issued only outside reset and stall; Ready is its one-hot form.
  always_comb begin
    grant_en_p0 = found_p0 && !bus.Hold && !Clr;
    ready_p0    = '0;
    for (int i = 0; i < NREQ; i++) begin
      ready_p0[i] = grant_en_p0 && (winner_p0 == 3'(i));
    end
  end

  // Route the winner's address and data toward the write-port registers.
  always_comb begin
    addr_sel_p0 = '0;
    data_sel_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner_p0 == 3'(i)) begin
        addr_sel_p0 = bus.Req_Addr[i*ADDR +: ADDR];
        data_sel_p0 = bus.Req_Data[i*SIZE +: SIZE];
      end
    end
  end

  // Flag any pair of simultaneously valid requesters targeting one address;
  // deliberately independent of Hold so software sees every contention.
  always_comb begin
    collision_p0 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (bus.Req_Valid[i] && bus.Req_Valid[j] &&
            (bus.Req_Addr[i*ADDR +: ADDR] == bus.Req_Addr[j*ADDR +: ADDR])) begin
          collision_p0 = 1'b1;
        end
      end
    end
  end

  // Priority moves to the requester just after the winner, wrapping to 0.
  always_comb begin
    if (winner_p0 == 3'(NREQ - 1)) begin
      ptr_next_p0 = 3'd0;
    end else begin
      ptr_next_p0 = winner_p0 + 3'd1;
    end
  end

  // ---- stage p1: registered write port ----
  logic            write_reg_p1;
  logic [ADDR-1:0] w_addr_p1;
  logic [SIZE-1:0] w_data_p1;
  logic [2:0]      grant_idx_p1;
  logic            collision_p1;

  // Latch the granted write; without a grant only the enable drops and the
  // last address/data/index stay visible. Clr discards any pending write.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      write_reg_p1 <= 1'b0;
      w_addr_p1    <= '0;
      w_data_p1    <= '0;
      grant_idx_p1 <= 3'd0;
      collision_p1 <= 1'b0;
      ptr          <= 3'd0;
    end else begin
      write_reg_p1 <= grant_en_p0;
      collision_p1 <= collision_p0;
      if (grant_en_p0) begin
        w_addr_p1    <= addr_sel_p0;
        w_data_p1    <= data_sel_p0;
        grant_idx_p1 <= winner_p0;
        ptr          <= ptr_next_p0;
      end
    end
  end

  assign bus.Req_Ready = ready_p0;
  assign bus.Write_Reg = write_reg_p1;
  assign bus.W_Addr    = w_addr_p1;
  assign bus.W_Data    = w_data_p1;
  assign bus.Grant_Idx = grant_idx_p1;
  assign bus.Collision = collision_p1;

endmodule
